mux2_1s: RTL and testbench

//  Control-signal bubble multiplexer for the ARMv8 5-stage pipeline.
//  - Sits between the main decoder and the ID/EX register.
//  - Passes Branch/RegWrite/MemRead/MemWrite through, or forces them all to 0 (a NOP bubble) when the hazard unit asserts Stall.
//  - Keeps a registered count of inserted bubbles for debug and performance visibility.

---
 rtl/mux2_1s_pkg.sv | 21 ++
 rtl/mux2_1s_bubble_counter.sv | 21 ++
 rtl/mux2_1s.sv | 61 ++++++
 tb/tb_mux2_1s.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mux2_1s_pkg.sv
// Shared pipeline control definitions: ID/EX control bundle and its NOP value.
package mux2_1s_pkg;

    localparam int unsigned CTRL_W = 4;

    // Bundle ordering {Branch, RegWrite, MemRead, MemWrite}
    typedef struct packed {
        logic branch;
        logic regWrite;
        logic memRead;
        logic memWrite;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{branch: 1'b0, regWrite: 1'b0, memRead: 1'b0, memWrite: 1'b0};

    // Squash a control bundle to NOP when bubbled; a bubble always wins.
    function automatic ctrl_t ctrlMask(input ctrl_t ctrl, input logic bubble);
        ctrlMask = bubble ? CTRL_NOP : ctrl;
    endfunction

endpackage

// File: rtl/mux2_1s_bubble_counter.sv
// Saturating event counter with asynchronous active-high clear.
module mux2_1s_bubble_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux2_1s.sv
// Control-signal bubble mux between decoder and ID/EX, with a bubble counter.
// Optional Flush input enabled by defining MUX2_1S_FLUSH_EN.
module mux2_1s
    import mux2_1s_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Branch,
    input  logic             RegWrite,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             Stall,
`ifdef MUX2_1S_FLUSH_EN
    input  logic             Flush,
`endif
    output logic             OutBranch,
    output logic             OutRegWrite,
    output logic             OutMemWrite,
    output logic             OutMemRead,
    output logic             Bubble,
    output logic [CNT_W-1:0] BubbleCount
);

    logic  bubbleReq;
    ctrl_t ctrlIn;
    ctrl_t ctrlOut;

`ifdef MUX2_1S_FLUSH_EN
    assign bubbleReq = Stall | Flush;
`else
    assign bubbleReq = Stall;
`endif

    // Reset also bubbles so nothing leaks into ID/EX while the pipe is held.
    assign Bubble = bubbleReq | Reset;

    assign ctrlIn = '{branch: Branch, regWrite: RegWrite, memRead: MemRead, memWrite: MemWrite};

    always_comb begin
        ctrlOut = CTRL_NOP;
        ctrlOut = ctrlMask(ctrlIn, Bubble);
    end

    assign OutBranch   = ctrlOut.branch;
    assign OutRegWrite = ctrlOut.regWrite;
    assign OutMemRead  = ctrlOut.memRead;
    assign OutMemWrite = ctrlOut.memWrite;

    // Reset is the async clear, so counting starts at the first edge after release.
    mux2_1s_bubble_counter #(
        .CNT_W(CNT_W)
    ) uCounter (
        .clk  (CLK),
        .clr  (Reset),
        .inc  (bubbleReq),
        .count(BubbleCount)
    );

endmodule

// File: tb/tb_mux2_1s.sv
// Directed bench for mux2_1s: a 16-bit and a 2-bit counter instance share stimulus.
module tb_mux2_1s;

    logic CLK = 1'b0;
    logic Reset, Branch, RegWrite, MemRead, MemWrite, Stall, Flush;
    logic OutBranch, OutRegWrite, OutMemWrite, OutMemRead, Bubble;
    logic [15:0] BubbleCount;
    logic sOutBranch, sOutRegWrite, sOutMemWrite, sOutMemRead, sBubble;
    logic [1:0] satCount;

    int total = 0;
    int bad = 0;
    longint model16 = 0;
    longint model2 = 0;
    int expSat[5] = '{1, 2, 3, 3, 3};

    always #5 CLK = ~CLK;

    mux2_1s #(.CNT_W(16)) dut (
        .CLK(CLK), .Reset(Reset), .Branch(Branch), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Stall(Stall),
`ifdef MUX2_1S_FLUSH_EN
        .Flush(Flush),
`endif
        .OutBranch(OutBranch), .OutRegWrite(OutRegWrite), .OutMemWrite(OutMemWrite),
        .OutMemRead(OutMemRead), .Bubble(Bubble), .BubbleCount(BubbleCount)
    );

    mux2_1s #(.CNT_W(2)) dutSat (
        .CLK(CLK), .Reset(Reset), .Branch(Branch), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Stall(Stall),
`ifdef MUX2_1S_FLUSH_EN
        .Flush(Flush),
`endif
        .OutBranch(sOutBranch), .OutRegWrite(sOutRegWrite), .OutMemWrite(sOutMemWrite),
        .OutMemRead(sOutMemRead), .Bubble(sBubble), .BubbleCount(satCount)
    );

    function automatic logic flushEff();
`ifdef MUX2_1S_FLUSH_EN
        return Flush;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count of clock edges with a bubble request, clipped at the max.
    always @(posedge Reset) begin
        model16 = 0;
        model2 = 0;
    end

    always @(posedge CLK) begin
        if (Reset === 1'b0 && (Stall | flushEff()) === 1'b1) begin
            model16 = (model16 + 1 > 65535) ? 65535 : model16 + 1;
            model2  = (model2 + 1 > 3) ? 3 : model2 + 1;
        end
    end

    // Every-cycle comparison against the reference.
    always @(negedge CLK) begin
        logic expBub;
        logic [3:0] expOut;
        expBub = Stall | flushEff() | Reset;
        expOut = expBub ? 4'b0000 : {Branch, RegWrite, MemRead, MemWrite};
        check("bubble", 64'(Bubble), 64'(expBub));
        check("outs", 64'({OutBranch, OutRegWrite, OutMemRead, OutMemWrite}), 64'(expOut));
        check("satOuts", 64'({sOutBranch, sOutRegWrite, sOutMemRead, sOutMemWrite, sBubble}),
              64'({expOut, expBub}));
        check("count16", 64'(BubbleCount), 64'(model16));
        check("count2", 64'(satCount), 64'(model2));
    end

    task automatic sync();
        @(posedge CLK);
        #2;
    endtask

    task automatic setIn(input logic [3:0] v);
        {Branch, RegWrite, MemRead, MemWrite} = v;
    endtask

    task automatic checkOuts(input string name, input logic [3:0] expOut, input logic expBub);
        check(name, 64'({OutBranch, OutRegWrite, OutMemRead, OutMemWrite, Bubble}),
              64'({expOut, expBub}));
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        setIn(4'b1111);
        #1;
        checkOuts("t1ResetOuts", 4'b0000, 1'b1);
        check("t1ResetCnt", 64'(BubbleCount), 64'd0);
        repeat (3) sync();
        check("t1ResetHold", 64'(BubbleCount), 64'd0);

        // Idle, no stall
        Reset = 1'b0; setIn(4'b0000);
        #1;
        checkOuts("t2Idle", 4'b0000, 1'b0);
        #99;
        check("t2CntHold", 64'(BubbleCount), 64'd0);

        // 100 ns stall window spans exactly 10 rising edges
        Stall = 1'b1;
        #1;
        checkOuts("t3Stall", 4'b0000, 1'b1);
        #99;
        check("t3Cnt", 64'(BubbleCount), 64'd10);
        check("t3Sat", 64'(satCount), 64'd3);
        Stall = 1'b0;
        #1;
        checkOuts("t3StallOff", 4'b0000, 1'b0);
        #99;
        check("t3CntHold", 64'(BubbleCount), 64'd10);

        // Pass-through and same-cycle masking
        setIn(4'b1111);
        #1;
        checkOuts("t4Pass", 4'b1111, 1'b0);
        Stall = 1'b1;
        #1;
        checkOuts("t4Mask", 4'b0000, 1'b1);
        Stall = 1'b0;
        #1;
        checkOuts("t4Unmask", 4'b1111, 1'b0);

        // Saturation on the 2-bit instance after a mid-clock reset pulse
        sync();
        Reset = 1'b1;
        #1;
        check("t5ClrCnt", 64'(BubbleCount), 64'd0);
        check("t5ClrSat", 64'(satCount), 64'd0);
        Reset = 1'b0;
        Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            check("t5SatStep", 64'(satCount), 64'(expSat[i]));
        end
        check("t5Cnt16", 64'(BubbleCount), 64'd5);
        #3;
        Reset = 1'b1;
        #1;
        check("t5MidClr", 64'(satCount), 64'd0);
        check("t5MidClr16", 64'(BubbleCount), 64'd0);

        // Reset released mid-stall: outputs follow Stall, first edge counts
        #2;
        Reset = 1'b0;
        #1;
        checkOuts("t5RelStall", 4'b0000, 1'b1);
        @(posedge CLK);
        #1;
        check("t5FirstEdge", 64'(BubbleCount), 64'd1);
        Stall = 1'b0;

        // Sweep every input pattern with varying stall
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            sync();
            setIn(v);
            Stall = v[0] ^ v[3];
            #1;
            checkOuts("sweep", (v[0] ^ v[3]) ? 4'b0000 : v, v[0] ^ v[3]);
        end
        sync();
        Stall = 1'b0;

`ifdef MUX2_1S_FLUSH_EN
        begin
            longint before;
            sync();
            setIn(4'b1111);
            before = model16;
            Flush = 1'b1;
            #1;
            checkOuts("t6Flush", 4'b0000, 1'b1);
            @(posedge CLK);
            #1;
            check("t6FlushCnt", 64'(BubbleCount), 64'(before + 1));
            Flush = 1'b0;
            #1;
            checkOuts("t6FlushOff", 4'b1111, 1'b0);
        end
`endif

        repeat (3) sync();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
